// File: rtl/dmem_responder.sv
// Purpose : single-port data-memory responder; byte/half/word loads and stores with alignment/range checking.
// Latency : response valid LATENCY+1 cycles after the accept cycle; memory is read/written on the edge entering RESP.
// Backpr. : one request in flight; req_ready only in IDLE; RESP holds the response stable until rsp_ready.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_addr, req_wdata, req_size, req_unsigned   request fields
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       response payload
module dmem_responder #(
    parameter int ADDR_WIDTH = 5,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        lat_we, lat_unsigned;
    logic [31:0] lat_addr, lat_wdata;
    logic [1:0]  lat_size;

    logic [31:0] mem [DEPTH];

    logic                  accept, enter_resp;
    logic                  acc_we, acc_unsigned;
    logic [31:0]           acc_addr, acc_wdata;
    logic [1:0]            acc_size;
    logic                  err;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic [3:0]            be;
    logic [31:0]           wd, word_rd, shifted, load_data;

    assign accept = req_ready && req_valid;

    // With zero latency the access happens on the accept edge itself, so the
    // live request fields are used; otherwise the latched copy is used.
    assign enter_resp = ((state == IDLE) && accept && (LATENCY == 0)) ||
                        ((state == WAIT) && (cnt == 4'd0));

    assign acc_we       = (state == IDLE) ? req_we       : lat_we;
    assign acc_unsigned = (state == IDLE) ? req_unsigned : lat_unsigned;
    assign acc_addr     = (state == IDLE) ? req_addr     : lat_addr;
    assign acc_wdata    = (state == IDLE) ? req_wdata    : lat_wdata;
    assign acc_size     = (state == IDLE) ? req_size     : lat_size;

    assign idx  = acc_addr[ADDR_WIDTH+1:2];
    assign lane = acc_addr[1:0];

    // Any address bit above the memory range is an error, so the byte just
    // past the top word never wraps back to word 0.
    assign err = (acc_size == 2'b11) ||
                 ((acc_size == 2'b01) && acc_addr[0]) ||
                 ((acc_size == 2'b10) && (acc_addr[1:0] != 2'b00)) ||
                 ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    // Store data replicated across lanes; byte enables pick which lanes land.
    always_comb begin
        be = 4'b0000;
        wd = acc_wdata;
        case (acc_size)
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be = lane[1] ? 4'b1100 : 4'b0011;
                wd = {2{acc_wdata[15:0]}};
            end
            2'b10: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    assign word_rd = mem[idx];
    assign shifted = word_rd >> {lane, 3'b000};

    always_comb begin
        load_data = word_rd;
        case (acc_size)
            2'b00: load_data = acc_unsigned ? {24'd0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            2'b01: load_data = acc_unsigned ? {16'd0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = word_rd;
        endcase
    end

    // Memory has no reset: contents survive rst, and a store pending when
    // rst hits is dropped because the FSM is forced back to IDLE.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_we && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wd[8*i +: 8];
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; req_ready is held low for the whole time rst is asserted.
    always_comb begin
        req_ready = (state == IDLE) && !rst;
        rsp_valid = (state == RESP);
    end

    // Wait counter, request latch and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= 4'd0;
            lat_we       <= 1'b0;
            lat_unsigned <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            lat_size     <= 2'b00;
            rsp_rdata    <= 32'd0;
            rsp_err      <= 1'b0;
        end else begin
            if (accept) begin
                cnt          <= CNT_INIT;
                lat_we       <= req_we;
                lat_unsigned <= req_unsigned;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                lat_size     <= req_size;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_err   <= err;
                rsp_rdata <= (err || acc_we) ? 32'd0 : load_data;
            end
        end
    end

endmodule
